// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle core.
// Owns the PC, fetches each instruction over a req/ack handshake, holds it
// for decode/execute and selects the next PC when execute completes.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned next-PC -> fetch error).
//
// Handshake: in REQ, o_imem_req is high and o_imem_addr (== o_pc) is held
// constant; the memory completes the fetch by raising i_imem_ack together with
// i_imem_rdata for one cycle. i_imem_ack outside REQ and i_ex_done outside
// HOLD are ignored.

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    input  logic        i_ex_done,
    input  logic        i_npc_op,
    input  logic        i_pc_sel,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu_c,
    output logic        o_fetch_err,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    // Last counter value still allowed to wait; an ack here still wins.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_fetch_err;
    logic [7:0]  r_cnt;

    logic [31:0] w_npc_raw;
    logic [31:0] w_npc_aligned;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        w_npc_misaligned;
`endif

    // Next-PC selection: JALR target beats PC+imm beats PC+4.
    always_comb begin
        w_npc_raw = r_pc + 32'd4;
        if (i_pc_sel) begin
            w_npc_raw = i_alu_c & ~32'h1;
        end else if (i_npc_op) begin
            w_npc_raw = r_pc + i_imm;
        end
    end

    assign w_npc_aligned = w_npc_raw & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
    assign w_npc_misaligned = (w_npc_raw != w_npc_aligned);
`endif

    // Fetch FSM: PC, held instruction, valid/error flags and timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_cnt        <= 8'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_imem_ack) begin
                        r_inst       <= i_imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_cnt        <= 8'd0;
                        r_state      <= S_HOLD;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt        <= 8'd0;
                        r_fetch_err  <= 1'b1;
                        r_state      <= S_ERR;
                    end else begin
                        r_cnt        <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (i_ex_done) begin
                        r_inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (w_npc_misaligned) begin
                            // Keep the faulting instruction's address in r_pc.
                            r_fetch_err <= 1'b1;
                            r_state     <= S_ERR;
                        end else begin
                            r_pc    <= w_npc_aligned;
                            r_state <= S_REQ;
                        end
`else
                        r_pc    <= w_npc_aligned;
                        r_state <= S_REQ;
`endif
                    end
                end
                S_ERR: begin
                    r_inst_valid <= 1'b0;
                    r_fetch_err  <= 1'b1;
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_fetch_err  <= 1'b1;
                    r_state      <= S_ERR;
                end
            endcase
        end
    end

    // Request is suppressed while reset is held so the reset cycle never fetches.
    assign o_imem_req   = (r_state == S_REQ) && !i_rst;
    assign o_imem_addr  = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_pc         = r_pc;
    assign o_pc4        = r_pc + 32'd4;
    assign o_fetch_err  = r_fetch_err;
    assign o_state      = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a behavioural PC model.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          ACK_TIMEOUT = 16;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        ex_done;
    logic        npc_op;
    logic        pc_sel;
    logic [31:0] imm;
    logic [31:0] alu_c;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    bit          model_err;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .o_pc         (pc),
        .o_pc4        (pc4),
        .i_ex_done    (ex_done),
        .i_npc_op     (npc_op),
        .i_pc_sel     (pc_sel),
        .i_imm        (imm),
        .i_alu_c      (alu_c),
        .o_fetch_err  (fetch_err),
        .o_state      (dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        ex_done    = 1'b0;
        npc_op     = 1'b0;
        pc_sel     = 1'b0;
        imm        = 32'h0;
        alu_c      = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        exp_pc    = RESET_PC;
        model_err = 1'b0;
    endtask

    // Fetch at exp_pc; memory acks after 'delay' wait cycles. Spurious ex_done
    // and next-PC controls during the wait must be ignored.
    task automatic fetch(input int delay, input logic [31:0] word);
        for (int k = 0; k <= delay; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                n_bad++;
                $display("FAIL fetch_req cycle %0d: req=%b addr=%h, required req=1 addr=%h",
                         k, imem_req, imem_addr, exp_pc);
            end
            imem_ack   = (k == delay);
            imem_rdata = (k == delay) ? word : $urandom;
            ex_done    = (k == delay) ? 1'b0 : 1'($urandom_range(0, 1));
            npc_op     = 1'($urandom_range(0, 1));
            pc_sel     = 1'($urandom_range(0, 1));
            imm        = $urandom;
            alu_c      = $urandom;
            step();
        end
        clear_inputs();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== word || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_hold: valid=%b inst=%h req=%b, required valid=1 inst=%h req=0",
                     inst_valid, inst, imem_req, word);
        end
        n_cmp++;
        if (pc !== exp_pc || pc4 !== exp_pc + 32'd4) begin
            n_bad++;
            $display("FAIL fetch_pc: pc=%h pc4=%h, required pc=%h pc4=%h",
                     pc, pc4, exp_pc, exp_pc + 32'd4);
        end
    endtask

    // Complete execute with the given next-PC controls and check the new PC.
    task automatic retire(input logic op, input logic sel, input logic [31:0] im,
                          input logic [31:0] alu);
        logic [31:0] raw;
        if (sel)     raw = alu & 32'hFFFF_FFFE;
        else if (op) raw = exp_pc + im;
        else         raw = exp_pc + 32'd4;
        npc_op  = op;
        pc_sel  = sel;
        imm     = im;
        alu_c   = alu;
        ex_done = 1'b1;
        step();
        clear_inputs();
`ifdef FETCH_ALIGN_CHECK_EN
        if (raw[1:0] != 2'b00) begin
            model_err = 1'b1;
        end else begin
            exp_pc = raw;
        end
`else
        exp_pc = {raw[31:2], 2'b00};
`endif
        n_cmp++;
        if (model_err) begin
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== exp_pc) begin
                n_bad++;
                $display("FAIL retire_err: err=%b req=%b valid=%b pc=%h, required err=1 req=0 valid=0 pc=%h",
                         fetch_err, imem_req, inst_valid, pc, exp_pc);
            end
        end else begin
            if (fetch_err !== 1'b0 || imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== exp_pc) begin
                n_bad++;
                $display("FAIL retire_npc: err=%b req=%b valid=%b addr=%h, required err=0 req=1 valid=0 addr=%h",
                         fetch_err, imem_req, inst_valid, imem_addr, exp_pc);
            end
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        clear_inputs();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        ex_done    = 1'b1;
        step();
        step();
        n_cmp++;
        if (pc !== RESET_PC || inst !== NOP_INST || inst_valid !== 1'b0 ||
            fetch_err !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: pc=%h inst=%h valid=%b err=%b req=%b, required pc=%h inst=%h valid=0 err=0 req=0",
                     pc, inst, inst_valid, fetch_err, imem_req, RESET_PC, NOP_INST);
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        exp_pc    = RESET_PC;
        model_err = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_release: req=%b addr=%h, required req=1 addr=%h",
                     imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            want = exp_q.pop_front();
            n_cmp++;
            if (imem_addr !== want) begin
                n_bad++;
                $display("FAIL seq_addr %0d: addr=%h, required %h", i, imem_addr, want);
            end
            fetch(0, $urandom);
            retire(1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_branch();
        fetch(0, $urandom);
        retire(1'b0, 1'b1, 32'h0, 32'h0000_0100);
        fetch(0, $urandom);
        retire(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0000_00F0) begin
            n_bad++;
            $display("FAIL branch_back: addr=%h, required 000000f0", imem_addr);
        end
        fetch(1, $urandom);
        retire(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0000_0110) begin
            n_bad++;
            $display("FAIL branch_fwd: addr=%h, required 00000110", imem_addr);
        end
    endtask

    // JALR wins over npc_op; target 0x2003 -> bit 0 cleared -> 0x2002, whose
    // bit 1 is then either forced to 0 (0x2000) or reported as a fetch error.
    task automatic test_jalr();
        fetch(0, $urandom);
        retire(1'b1, 1'b1, 32'h0000_0040, 32'h0000_2003);
`ifdef FETCH_ALIGN_CHECK_EN
        do_reset();
`else
        n_cmp++;
        if (imem_addr !== 32'h0000_2000) begin
            n_bad++;
            $display("FAIL jalr_target: addr=%h, required 00002000", imem_addr);
        end
`endif
    endtask

    task automatic test_wait_states();
        fetch(3, $urandom);
        retire(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < ACK_TIMEOUT; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait cycle %0d: req=%b err=%b, required req=1 err=0",
                         k, imem_req, fetch_err);
            end
            step();
        end
        n_cmp++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: err=%b req=%b valid=%b, required err=1 req=0 valid=0",
                     fetch_err, imem_req, inst_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        ex_done    = 1'b1;
        for (int k = 0; k < 3; k++) step();
        clear_inputs();
        n_cmp++;
        if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || inst !== NOP_INST) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b valid=%b inst=%h, required err=1 valid=0 inst=%h",
                     fetch_err, inst_valid, inst, NOP_INST);
        end
        do_reset();
    endtask

    task automatic test_ack_last();
        fetch(ACK_TIMEOUT - 1, $urandom);
        n_cmp++;
        if (fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_last: err=%b, required 0", fetch_err);
        end
        retire(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_ignore_ack_in_hold();
        logic [31:0] word;
        word = $urandom;
        fetch(0, word);
        imem_ack   = 1'b1;
        imem_rdata = ~word;
        step();
        step();
        clear_inputs();
        n_cmp++;
        if (inst !== word || inst_valid !== 1'b1 || pc !== exp_pc) begin
            n_bad++;
            $display("FAIL hold_ack_ignored: inst=%h valid=%b pc=%h, required inst=%h valid=1 pc=%h",
                     inst, inst_valid, pc, word, exp_pc);
        end
        retire(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_wrap();
        fetch(0, $urandom);
        retire(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        fetch(0, $urandom);
        n_cmp++;
        if (pc4 !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_pc4: pc4=%h, required 00000000", pc4);
        end
        retire(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_addr: addr=%h, required 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        fetch(0, $urandom);
        retire(1'b0, 1'b1, 32'h0, 32'h0000_0500);
        step();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        n_cmp++;
        if (pc !== RESET_PC || inst_valid !== 1'b0 || inst !== NOP_INST || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_fetch: pc=%h valid=%b inst=%h req=%b, required pc=%h valid=0 inst=%h req=0",
                     pc, inst_valid, inst, imem_req, RESET_PC, NOP_INST);
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        exp_pc    = RESET_PC;
        model_err = 1'b0;
        fetch(1, $urandom);
        retire(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            fetch($urandom_range(0, 4), $urandom);
            retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end
    endtask

    // Sequencer and final report
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_pc    = RESET_PC;
        model_err = 1'b0;
        rst       = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_wait_states();
        test_timeout();
        test_ack_last();
        test_ignore_ack_in_hold();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
